// File: rtl/mips_pkg.sv
// Shared MIPS EX-stage encodings: ALUControl codes, multiply/divide ops, MDU FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

  // Multiply/divide operation selector driven on the unit's op port.
  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_t;

  // ALUControl encodings shared with the ALU decoder.
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_MUL = 4'b0010;
  localparam logic [3:0] ALU_DIV = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_AND = 4'b1000;
  localparam logic [3:0] ALU_OR  = 4'b1001;
  localparam logic [3:0] ALU_XOR = 4'b1010;
  localparam logic [3:0] ALU_NOR = 4'b1011;

  // Multiply/divide sequencer states.
  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_RUN  = 2'b01,
    MDU_FIX  = 2'b10
  } mdu_state_t;

  // Divide ops have the upper op bit set.
  function automatic logic mdu_is_div(input mdu_op_t o);
    return o[1];
  endfunction

  // Signed ops (MULT, DIV) have the lower op bit clear.
  function automatic logic mdu_is_signed(input mdu_op_t o);
    return ~o[0];
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One multiply/divide iteration on the 2*WIDTH accumulator (shift-add or restoring shift-subtract).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to register the result.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  // Multiply: add multiplicand into the upper half when the product LSB is set, then shift right.
  // Divide: shift remainder:quotient left, trial-subtract divisor, keep it only if no borrow.
  always_comb begin
    add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    diff     = rem_sh - {1'b0, operand};
    acc_next = {add_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      // The remainder stays below the divisor, so bit WIDTH of diff is a clean borrow flag.
      if (!diff[WIDTH]) begin
        acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {acc[2*WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO, sitting in EX next to the ALU.
// Latency: 33 cycles from the accepting edge until HI/LO hold the result (done pulses then).
// Backpressure: busy stalls the pipeline; start and MTHI/MTLO writes are ignored while busy.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int              CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0]   LAST = CW'(ITER - 1);

  mdu_state_t         state, state_nxt;
  logic [CW-1:0]      cnt;
  logic               is_div_q;
  logic               neg_q;       // negate product / quotient
  logic               rem_neg_q;   // remainder takes the dividend's sign
  logic               dz_q;        // this divide had a zero divisor
  logic [WIDTH-1:0]   a_raw_q;     // unmodified dividend for the divide-by-zero result
  logic [WIDTH-1:0]   operand_q;   // |A| for multiply, |B| for divide
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;

  mdu_op_t            op_in;
  logic               in_signed;
  logic               in_div;
  logic               sa, sb;
  logic [WIDTH-1:0]   a_abs, b_abs;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign busy = (state != MDU_IDLE);

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div_q),
    .acc      (acc),
    .operand  (operand_q),
    .acc_next (acc_step)
  );

  // Decode the incoming op and take operand magnitudes for signed ops.
  always_comb begin
    op_in     = mdu_op_t'(op);
    in_signed = mdu_is_signed(op_in);
    in_div    = mdu_is_div(op_in);
    sa        = in_signed & A[WIDTH-1];
    sb        = in_signed & B[WIDTH-1];
    a_abs     = sa ? -A : A;
    b_abs     = sb ? -B : B;
  end

  // Sign-correct the finished accumulator and pick the HI/LO values to commit.
  always_comb begin
    prod   = neg_q ? -acc : acc;
    quo    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem    = rem_neg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (is_div_q) begin
      if (dz_q) begin
        res_hi = a_raw_q;
        res_lo = '1;
      end else begin
        res_hi = rem;
        res_lo = quo;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MDU_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: accept in IDLE, iterate ITER times in RUN, one FIX cycle to commit.
  always_comb begin
    state_nxt = state;
    case (state)
      MDU_IDLE: if (start) state_nxt = MDU_RUN;
      MDU_RUN:  if (cnt == LAST) state_nxt = MDU_FIX;
      MDU_FIX:  state_nxt = MDU_IDLE;
      default:  state_nxt = MDU_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, result commit and MTHI/MTLO writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      HI          <= '0;
      LO          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      is_div_q    <= 1'b0;
      neg_q       <= 1'b0;
      rem_neg_q   <= 1'b0;
      dz_q        <= 1'b0;
      a_raw_q     <= '0;
      operand_q   <= '0;
      acc         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        MDU_IDLE: begin
          if (start) begin
            // A start in the same cycle as MTHI/MTLO drops the register write.
            is_div_q    <= in_div;
            neg_q       <= sa ^ sb;
            rem_neg_q   <= sa;
            dz_q        <= in_div && (B == '0);
            a_raw_q     <= A;
            operand_q   <= in_div ? b_abs : a_abs;
            acc         <= {{WIDTH{1'b0}}, (in_div ? a_abs : b_abs)};
            cnt         <= '0;
            div_by_zero <= 1'b0;
          end else begin
            if (hi_we) HI <= wdata;
            if (lo_we) LO <= wdata;
          end
        end
        MDU_RUN: begin
          acc <= acc_step;
          cnt <= cnt + CW'(1);
        end
        MDU_FIX: begin
          HI          <= res_hi;
          LO          <= res_lo;
          done        <= 1'b1;
          div_by_zero <= dz_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit with a cycle-level reference model and literal result checks.
// Latency: model commits 33 edges after the accepting edge.
// Backpressure: model ignores start/MTHI/MTLO while busy.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A, B, wdata;
  logic        hi_we, lo_we;
  logic        busy, done, div_by_zero;
  logic [31:0] HI, LO;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .A           (A),
    .B           (B),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .HI          (HI),
    .LO          (LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Architectural result of one operation from plain arithmetic.
  function automatic void ref_calc(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] h, output logic [31:0] l, output logic dz);
    logic [63:0] p;
    int sa, sb;
    sa = a;
    sb = b;
    dz = 1'b0;
    h  = '0;
    l  = '0;
    case (o)
      2'b00: begin p = longint'(sa) * longint'(sb); h = p[63:32]; l = p[31:0]; end
      2'b01: begin p = {32'b0, a} * {32'b0, b};     h = p[63:32]; l = p[31:0]; end
      2'b10: begin
        if (b == 32'd0) begin h = a; l = 32'hFFFFFFFF; dz = 1'b1; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin h = 32'd0; l = 32'h80000000; end
        else begin l = sa / sb; h = sa % sb; end
      end
      default: begin
        if (b == 32'd0) begin h = a; l = 32'hFFFFFFFF; dz = 1'b1; end
        else begin l = a / b; h = a % b; end
      end
    endcase
  endfunction

  // Reference model state.
  logic        m_busy, m_done, m_dz;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        p_dz;
  int          m_left;

  // Model: on accept, compute the answer and let it land 33 edges later.
  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
      m_hi = '0; m_lo = '0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0; m_done = 1'b1;
          m_hi = p_hi; m_lo = p_lo;
          if (p_dz) m_dz = 1'b1;
        end
      end else if (start) begin
        ref_calc(op, A, B, p_hi, p_lo, p_dz);
        m_dz = 1'b0; m_busy = 1'b1; m_left = 33;
      end else begin
        if (hi_we) m_hi = wdata;
        if (lo_we) m_lo = wdata;
      end
    end
  end

  // Compare every output against the model each cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk_b("m_busy", busy, m_busy);
      chk_b("m_done", done, m_done);
      chk_b("m_dz", div_by_zero, m_dz);
      chk("m_hi", HI, m_hi);
      chk("m_lo", LO, m_lo);
    end
  end

  // Drive start at the current negedge; returns one negedge later.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done, returning in the done cycle.
  task automatic wait_done(input string name);
    int k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk_b({name, "_done"}, done, 1'b1);
  endtask

  typedef struct { logic [1:0] o; logic [31:0] a; logic [31:0] b; } vec_t;
  vec_t extra[5];

  initial begin
    reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; A = '0; B = '0; wdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cmp_en = 1'b1;
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_done", done, 1'b0);
    chk_b("rst_dz", div_by_zero, 1'b0);
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);

    @(negedge clk);
    issue(2'b00, 32'd7, 32'hFFFFFFFD);
    chk_b("accept_busy", busy, 1'b1);
    wait_done("mult");
    chk_b("mult_busy_low", busy, 1'b0);
    chk("mult_hi", HI, 32'hFFFFFFFF);
    chk("mult_lo", LO, 32'hFFFFFFEB);
    @(negedge clk);
    chk_b("done_one_cycle", done, 1'b0);

    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("multu");
    chk("multu_hi", HI, 32'hFFFFFFFE);
    chk("multu_lo", LO, 32'h00000001);

    @(negedge clk);
    issue(2'b10, 32'hFFFFFFF9, 32'd2);
    wait_done("div");
    chk("div_lo", LO, 32'hFFFFFFFD);
    chk("div_hi", HI, 32'hFFFFFFFF);

    @(negedge clk);
    issue(2'b11, 32'h12345678, 32'h100);
    wait_done("divu");
    chk("divu_lo", LO, 32'h00123456);
    chk("divu_hi", HI, 32'h00000078);

    @(negedge clk);
    issue(2'b10, 32'd7, 32'hFFFFFFFE);
    wait_done("div_negb");
    chk("div_negb_lo", LO, 32'hFFFFFFFD);
    chk("div_negb_hi", HI, 32'h00000001);

    @(negedge clk);
    issue(2'b11, 32'd100, 32'd0);
    wait_done("dz");
    chk("dz_hi", HI, 32'h00000064);
    chk("dz_lo", LO, 32'hFFFFFFFF);
    chk_b("dz_flag", div_by_zero, 1'b1);
    @(negedge clk);
    chk_b("dz_held", div_by_zero, 1'b1);
    issue(2'b00, 32'd3, 32'd5);
    chk_b("dz_cleared", div_by_zero, 1'b0);

    // Start and MTHI while busy must both be dropped.
    repeat (9) @(negedge clk);
    start = 1'b1; op = 2'b00; A = 32'd9; B = 32'd9; hi_we = 1'b1; wdata = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    wait_done("ignore");
    chk("ignore_hi", HI, 32'h0);
    chk("ignore_lo", LO, 32'd15);

    // Back-to-back: start presented in the done cycle.
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF);
    chk_b("b2b_busy", busy, 1'b1);
    wait_done("ovf");
    chk("ovf_lo", LO, 32'h80000000);
    chk("ovf_hi", HI, 32'h0);
    chk_b("ovf_noflag", div_by_zero, 1'b0);

    // Start together with MTHI/MTLO in IDLE: start wins.
    @(negedge clk);
    start = 1'b1; op = 2'b01; A = 32'd2; B = 32'd3;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5A5A5A5A;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    wait_done("collide");
    chk("collide_hi", HI, 32'h0);
    chk("collide_lo", LO, 32'd6);

    for (int i = 0; i < 5; i++) begin
      extra[i].o = 2'(i % 4);
      extra[i].a = 32'h80000000 >> i;
      extra[i].b = 32'hFFFFFFF0 + 32'(i * 3);
    end
    foreach (extra[i]) begin
      @(negedge clk);
      issue(extra[i].o, extra[i].a, extra[i].b);
      wait_done("extra");
    end

    // Reset at iteration 10 aborts the divide.
    @(negedge clk);
    issue(2'b10, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_b("abort_busy", busy, 1'b0);
    chk_b("abort_done", done, 1'b0);
    chk("abort_hi", HI, 32'h0);
    chk("abort_lo", LO, 32'h0);
    begin
      int seen = 0;
      repeat (40) begin
        @(negedge clk);
        if (done) seen++;
      end
      chk("abort_no_done", 32'(seen), 32'd0);
    end

    lo_we = 1'b1; wdata = 32'hABCD1234;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo", LO, 32'hABCD1234);
    chk("mtlo_hi_untouched", HI, 32'h0);
    hi_we = 1'b1; wdata = 32'h13572468;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi", HI, 32'h13572468);
    @(negedge clk);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
